scoreboard_top: RTL and testbench

- Two-player score counter with a two-digit 7-segment display, clocked from a 1 kHz system clock (1 cycle = 1 ms).
- Each player has one pushbutton:
  - Short press adds one point to that player's score.
  - Long press clears both scores.
- Internally it contains two pushbutton processors (debounce plus short/long classification), two 0–99 score counters, a display-select controller, a binary-to-BCD converter and two 7-segment encoders.

---
 rtl/scoreboard_top.sv | 186 ++++++++++++++++++
 tb/tb_scoreboard_top.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_top.sv
// rtl/scoreboard_top.sv - two-player pushbutton scoreboard with two-digit 7-segment display

// sb_button - synchronizer, debounce and short/long press classification for one button
module sb_button #(
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic short_pulse,
  output logic long_pulse
);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int LW = $clog2(LONG_MS + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MS - 1);
  localparam logic [LW-1:0] LONG_FULL = LW'(LONG_MS);

  logic          sync1, sync2;
  logic          deb, deb_d;
  logic          armed;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] rel_cnt;
  logic [LW-1:0] hold_cnt;

  // two-flop synchronizer for the asynchronous raw button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // debounced level follows the synchronized level once it has differed for DEBOUNCE_MS samples
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      deb    <= 1'b0;
    end else if (sync2 != deb) begin
      if (db_cnt == DB_LAST) begin
        deb    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // events stay suppressed after reset until the button is seen released for DEBOUNCE_MS cycles,
  // so a press held through reset is discarded rather than reported
  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      rel_cnt <= '0;
    end else if (!armed) begin
      if (!sync1 && !sync2 && !deb) begin
        if (rel_cnt == DB_LAST) armed <= 1'b1;
        else                    rel_cnt <= rel_cnt + 1'b1;
      end else begin
        rel_cnt <= '0;
      end
    end
  end

  // hold timer runs while debounced high and saturates at LONG_MS
  always_ff @(posedge clk) begin
    if (rst || !deb) hold_cnt <= '0;
    else if (hold_cnt != LONG_FULL) hold_cnt <= hold_cnt + 1'b1;
  end

  // long pulse once when the timer reaches LONG_MS; short pulse on release if it never did
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_d       <= 1'b0;
      long_pulse  <= 1'b0;
      short_pulse <= 1'b0;
    end else begin
      deb_d       <= deb;
      long_pulse  <= armed && deb && (hold_cnt == LONG_LAST);
      short_pulse <= armed && deb_d && !deb && (hold_cnt != LONG_FULL);
    end
  end
endmodule

// sb_seg7 - BCD digit to active-high segments, bit0 = a .. bit6 = g, blank for non-digits
module sb_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  // digit decode table
  always_comb begin
    seg = 7'b0000000;
    case (digit)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end
endmodule

// scoreboard_top - score keeping, display select and registered segment outputs
module scoreboard_top #(
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int MAX_SCORE   = 99
) (
  input  logic       clk_1khz_i,
  input  logic       rst_i,
  input  logic       pushbutton_p1_i,
  input  logic       pushbutton_p2_i,
  output logic [6:0] seg_tens_o,
  output logic [6:0] seg_ones_o
);
  localparam logic [6:0] SCORE_MAX = 7'(MAX_SCORE);
  localparam logic [6:0] SEG_ZERO  = 7'b0111111;

  logic       p1_short, p1_long, p2_short, p2_long, any_long;
  logic [6:0] p1_score, p2_score, shown;
  logic       sel_p2;
  logic [3:0] tens, ones;
  logic [6:0] tens_seg, ones_seg;

  sb_button #(.DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS)) u_btn_p1 (
    .clk(clk_1khz_i), .rst(rst_i), .btn_raw(pushbutton_p1_i),
    .short_pulse(p1_short), .long_pulse(p1_long)
  );

  sb_button #(.DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS)) u_btn_p2 (
    .clk(clk_1khz_i), .rst(rst_i), .btn_raw(pushbutton_p2_i),
    .short_pulse(p2_short), .long_pulse(p2_long)
  );

  assign any_long = p1_long | p2_long;

  // score counters: a long press from either player clears both and beats any increment
  always_ff @(posedge clk_1khz_i) begin
    if (rst_i || any_long) begin
      p1_score <= '0;
      p2_score <= '0;
    end else begin
      if (p1_short) p1_score <= (p1_score == SCORE_MAX) ? 7'd0 : p1_score + 7'd1;
      if (p2_short) p2_score <= (p2_score == SCORE_MAX) ? 7'd0 : p2_score + 7'd1;
    end
  end

  // display follows the last player to score; P1 wins a tie and any long press returns to P1
  always_ff @(posedge clk_1khz_i) begin
    if (rst_i || any_long || p1_short) sel_p2 <= 1'b0;
    else if (p2_short)                 sel_p2 <= 1'b1;
  end

  // binary to BCD of the selected score
  always_comb begin
    shown = sel_p2 ? p2_score : p1_score;
    tens  = 4'(shown / 7'd10);
    ones  = 4'(shown % 7'd10);
  end

  sb_seg7 u_seg_tens (.digit(tens), .seg(tens_seg));
  sb_seg7 u_seg_ones (.digit(ones), .seg(ones_seg));

  // registered segment outputs, showing "00" from reset
  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      seg_tens_o <= SEG_ZERO;
      seg_ones_o <= SEG_ZERO;
    end else begin
      seg_tens_o <= tens_seg;
      seg_ones_o <= ones_seg;
    end
  end
endmodule

// File: tb/tb_scoreboard_top.sv
// tb/tb_scoreboard_top.sv - directed self-checking bench for scoreboard_top

module tb_scoreboard_top;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;
  logic [6:0] seg_tens, seg_ones;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  scoreboard_top dut (
    .clk_1khz_i(clk),
    .rst_i(rst),
    .pushbutton_p1_i(p1),
    .pushbutton_p2_i(p2),
    .seg_tens_o(seg_tens),
    .seg_ones_o(seg_ones)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 1) p1 = v;
    else            p2 = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; p1 = 1'b0; p2 = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(30);
  endtask

  task automatic press_bouncy(input int which);
    set_btn(which, 1'b1); wait_cycles(1);
    set_btn(which, 1'b0); wait_cycles(2);
    set_btn(which, 1'b1); wait_cycles(1);
    set_btn(which, 1'b0); wait_cycles(1);
    set_btn(which, 1'b1); wait_cycles(25);
    set_btn(which, 1'b0); wait_cycles(1);
    set_btn(which, 1'b1); wait_cycles(2);
    set_btn(which, 1'b0); wait_cycles(1);
    set_btn(which, 1'b1); wait_cycles(1);
    set_btn(which, 1'b0); wait_cycles(465);
  endtask

  task automatic press_clean(input int which, input int hold, input int gap);
    set_btn(which, 1'b1); wait_cycles(hold);
    set_btn(which, 1'b0); wait_cycles(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1; p1 = 1'b0; p2 = 1'b0;
    wait_cycles(2);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL reset_during: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
    rst = 1'b0;
    wait_cycles(30);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL reset_idle: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
  endtask

  task automatic test_long_from_idle();
    p1 = 1'b1;
    wait_cycles(1600);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL long_idle_held: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
    p1 = 1'b0;
    wait_cycles(100);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL long_idle_release: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
  endtask

  task automatic test_short_presses();
    for (int i = 0; i < 5; i++) press_bouncy(1);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[5]) begin
      bad++; $display("FAIL five_presses: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[5]);
    end
    for (int i = 0; i < 5; i++) press_bouncy(1);
    total++;
    if (seg_tens !== seg_tab[1] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL ten_presses: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[1], seg_tab[0]);
    end
    press_clean(1, 3, 50);
    total++;
    if (seg_tens !== seg_tab[1] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL glitch_3ms: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[1], seg_tab[0]);
    end
    press_clean(1, 9, 50);
    total++;
    if (seg_tens !== seg_tab[1] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL stable_9ms: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[1], seg_tab[0]);
    end
  endtask

  task automatic test_long_clear();
    p1 = 1'b1;
    wait_cycles(1005);
    total++;
    if (seg_tens !== seg_tab[1] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL before_long: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[1], seg_tab[0]);
    end
    wait_cycles(595);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL long_cleared: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
    p1 = 1'b0;
    wait_cycles(100);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL long_no_short: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
    press_bouncy(1);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[1]) begin
      bad++; $display("FAIL after_long_press: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[1]);
    end
    press_clean(1, 10, 50);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[2]) begin
      bad++; $display("FAIL stable_10ms: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[2]);
    end
  endtask

  task automatic test_p2_select();
    do_reset();
    for (int i = 0; i < 3; i++) press_clean(2, 20, 40);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[3]) begin
      bad++; $display("FAIL p2_three: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[3]);
    end
    press_clean(1, 20, 40);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[1]) begin
      bad++; $display("FAIL p1_after_p2: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[1]);
    end
    press_clean(2, 20, 40);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[4]) begin
      bad++; $display("FAIL p2_retained: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[4]);
    end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    p1 = 1'b1;
    wait_cycles(30);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(200);
    p1 = 1'b0;
    wait_cycles(100);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL mid_press_discard: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
    press_clean(1, 20, 40);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[1]) begin
      bad++; $display("FAIL mid_press_rearm: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[1]);
    end
  endtask

  task automatic test_wrap_and_collision();
    do_reset();
    for (int i = 0; i < 99; i++) press_clean(1, 15, 25);
    total++;
    if (seg_tens !== seg_tab[9] || seg_ones !== seg_tab[9]) begin
      bad++; $display("FAIL score_99: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[9], seg_tab[9]);
    end
    press_clean(1, 15, 25);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL wrap_00: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
    press_clean(2, 15, 25);
    press_clean(1, 15, 25);
    press_clean(1, 15, 25);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[2]) begin
      bad++; $display("FAIL pre_collision: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[2]);
    end
    // P2 release lands its short pulse in the same cycle as P1's long pulse
    p1 = 1'b1;
    wait_cycles(969);
    p2 = 1'b1;
    wait_cycles(30);
    p2 = 1'b0;
    wait_cycles(101);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0]) begin
      bad++; $display("FAIL collision_clear: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[0]);
    end
    p1 = 1'b0;
    wait_cycles(100);
    press_clean(2, 15, 25);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[1]) begin
      bad++; $display("FAIL collision_p2: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[1]);
    end
    press_clean(1, 15, 25);
    total++;
    if (seg_tens !== seg_tab[0] || seg_ones !== seg_tab[1]) begin
      bad++; $display("FAIL collision_p1: got %b %b want %b %b", seg_tens, seg_ones, seg_tab[0], seg_tab[1]);
    end
  endtask

  initial begin
    test_reset();
    test_long_from_idle();
    test_short_presses();
    test_long_clear();
    test_p2_select();
    test_reset_mid_press();
    test_wrap_and_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
